// File: rtl/prefix_pkg.sv
// Shared Kogge-Stone prefix types and helpers for the pipelined subtractor.
package prefix_pkg;

   typedef struct packed {
      logic p;
      logic g;
   } pg_t;

   function automatic pg_t pg_black(input pg_t hi, input pg_t lo);
      pg_t r;
      r.p = hi.p & lo.p;
      r.g = hi.g | (hi.p & lo.g);
      return r;
   endfunction

   function automatic int levels(input int w);
      return $clog2(w);
   endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone level: bit i merges with bit i-DIST, lower bits pass through.
module ks_prefix_level
   import prefix_pkg::*;
#(
   parameter int W    = 16,
   parameter int DIST = 1
) (
   input  pg_t [W-1:0] pg_in,
   output pg_t [W-1:0] pg_out
);

   for (genvar i = 0; i < W; i++) begin : g_bit
      if (i >= DIST) begin : g_black
         assign pg_out[i] = pg_black(pg_in[i], pg_in[i-DIST]);
      end else begin : g_pass
         assign pg_out[i] = pg_in[i];
      end
   end

endmodule

// File: rtl/subtractor_koggestone_pipe.sv
// Three-stage Kogge-Stone subtractor (a + ~b + 1) with valid/ready streaming on both sides.
// Define SUBTRACTOR_SAT_EN to enable signed-overflow detection and saturation of out_diff.
module subtractor_koggestone_pipe
   import prefix_pkg::*;
#(
   parameter int W     = 16,
   parameter int SPLIT = levels(W) / 2,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_diff,
   output logic             out_bout,
   output logic             out_ovf,
   output logic [TAG_W-1:0] out_tag
);

   localparam int L = levels(W);

   logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic             rdy1, rdy2, rdy3;
   logic             load1, load2, load3;

   pg_t  [W-1:0]     in_pg;
   pg_t  [W-1:0]     r1_pg_q, r1_pg_d;
   logic [TAG_W-1:0] r1_tag_q, r1_tag_d;
   pg_t  [W-1:0]     r2_pg_q, r2_pg_d;
   logic [W-1:0]     r2_p_q, r2_p_d;
   logic [TAG_W-1:0] r2_tag_q, r2_tag_d;
`ifdef SUBTRACTOR_SAT_EN
   logic             r1_amsb_q, r1_amsb_d, r1_bmsb_q, r1_bmsb_d;
   logic             r2_amsb_q, r2_amsb_d, r2_bmsb_q, r2_bmsb_d;
`endif

   logic [W-1:0]     out_diff_q, out_diff_d;
   logic             out_bout_q, out_bout_d;
   logic             out_ovf_q, out_ovf_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;

   pg_t  [W-1:0]     lvl [0:L];
   pg_t  [W-1:0]     grp;
   logic [W-1:0]     diff_raw, diff_fin;
   logic             bout_raw, ovf_raw;
   logic             unused_grp_p;

   // Prefix chain: levels below SPLIT feed R2, levels from SPLIT onward start from R2.
   assign lvl[0] = r1_pg_q;
   for (genvar k = 0; k < L; k++) begin : g_level
      if (k == SPLIT) begin : g_after_reg
         ks_prefix_level #(.W(W), .DIST(1 << k)) u_level (
            .pg_in  (r2_pg_q),
            .pg_out (lvl[k+1])
         );
      end else begin : g_chain
         ks_prefix_level #(.W(W), .DIST(1 << k)) u_level (
            .pg_in  (lvl[k]),
            .pg_out (lvl[k+1])
         );
      end
   end

   if (SPLIT == L) begin : g_grp_reg
      assign grp = r2_pg_q;
   end else begin : g_grp_comb
      assign grp = lvl[L];
   end

   always_comb begin
      // Ready ripples back from the output; an empty stage always accepts.
      rdy3  = !v3_q | out_ready;
      rdy2  = !v2_q | rdy3;
      rdy1  = !v1_q | rdy2;
      load1 = rdy1 & in_valid;
      load2 = rdy2 & v1_q;
      load3 = rdy3 & v2_q;
      v1_d  = rdy1 ? in_valid : v1_q;
      v2_d  = rdy2 ? v1_q : v2_q;
      v3_d  = rdy3 ? v2_q : v3_q;

      // The +1 carry-in is absorbed into bit 0's generate term.
      for (int i = 0; i < W; i++) begin
         in_pg[i].p = in_a[i] ^ ~in_b[i];
         in_pg[i].g = in_a[i] & ~in_b[i];
      end
      in_pg[0].g = in_a[0] | ~in_b[0];

      diff_raw[0] = r2_p_q[0] ^ 1'b1;
      for (int i = 1; i < W; i++) begin
         diff_raw[i] = r2_p_q[i] ^ grp[i-1].g;
      end
      bout_raw = ~grp[W-1].g;

      unused_grp_p = 1'b0;
      for (int i = 0; i < W; i++) begin
         unused_grp_p = unused_grp_p ^ grp[i].p;
      end

`ifdef SUBTRACTOR_SAT_EN
      ovf_raw  = (r2_amsb_q != r2_bmsb_q) & (diff_raw[W-1] != r2_amsb_q);
      diff_fin = diff_raw;
      if (ovf_raw) begin
         diff_fin = r2_amsb_q ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
`else
      ovf_raw  = 1'b0;
      diff_fin = diff_raw;
`endif

      r1_pg_d    = r1_pg_q;
      r1_tag_d   = r1_tag_q;
      r2_pg_d    = r2_pg_q;
      r2_p_d     = r2_p_q;
      r2_tag_d   = r2_tag_q;
      out_diff_d = out_diff_q;
      out_bout_d = out_bout_q;
      out_ovf_d  = out_ovf_q;
      out_tag_d  = out_tag_q;
`ifdef SUBTRACTOR_SAT_EN
      r1_amsb_d  = r1_amsb_q;
      r1_bmsb_d  = r1_bmsb_q;
      r2_amsb_d  = r2_amsb_q;
      r2_bmsb_d  = r2_bmsb_q;
`endif

      if (load1) begin
         r1_pg_d  = in_pg;
         r1_tag_d = in_tag;
`ifdef SUBTRACTOR_SAT_EN
         r1_amsb_d = in_a[W-1];
         r1_bmsb_d = in_b[W-1];
`endif
      end
      if (load2) begin
         r2_pg_d  = lvl[SPLIT];
         for (int i = 0; i < W; i++) begin
            r2_p_d[i] = r1_pg_q[i].p;
         end
         r2_tag_d = r1_tag_q;
`ifdef SUBTRACTOR_SAT_EN
         r2_amsb_d = r1_amsb_q;
         r2_bmsb_d = r1_bmsb_q;
`endif
      end
      if (load3) begin
         out_diff_d = diff_fin;
         out_bout_d = bout_raw;
         out_ovf_d  = ovf_raw;
         out_tag_d  = r2_tag_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q       <= 1'b0;
         v2_q       <= 1'b0;
         v3_q       <= 1'b0;
         r1_pg_q    <= '0;
         r1_tag_q   <= '0;
         r2_pg_q    <= '0;
         r2_p_q     <= '0;
         r2_tag_q   <= '0;
         out_diff_q <= '0;
         out_bout_q <= 1'b0;
         out_ovf_q  <= 1'b0;
         out_tag_q  <= '0;
`ifdef SUBTRACTOR_SAT_EN
         r1_amsb_q  <= 1'b0;
         r1_bmsb_q  <= 1'b0;
         r2_amsb_q  <= 1'b0;
         r2_bmsb_q  <= 1'b0;
`endif
      end else begin
         v1_q       <= v1_d;
         v2_q       <= v2_d;
         v3_q       <= v3_d;
         r1_pg_q    <= r1_pg_d;
         r1_tag_q   <= r1_tag_d;
         r2_pg_q    <= r2_pg_d;
         r2_p_q     <= r2_p_d;
         r2_tag_q   <= r2_tag_d;
         out_diff_q <= out_diff_d;
         out_bout_q <= out_bout_d;
         out_ovf_q  <= out_ovf_d;
         out_tag_q  <= out_tag_d;
`ifdef SUBTRACTOR_SAT_EN
         r1_amsb_q  <= r1_amsb_d;
         r1_bmsb_q  <= r1_bmsb_d;
         r2_amsb_q  <= r2_amsb_d;
         r2_bmsb_q  <= r2_bmsb_d;
`endif
      end
   end

   assign in_ready  = rdy1;
   assign out_valid = v3_q;
   assign out_diff  = out_diff_q;
   assign out_bout  = out_bout_q;
   assign out_ovf   = out_ovf_q;
   assign out_tag   = out_tag_q;

endmodule
